// File: rtl/innings_ctrl.sv
// Scorecard sequencer: turns each accepted delivery into single-cycle increment
// pulses for the score/ball/wicket counters and keeps binary shadow totals.
module innings_ctrl #(
  parameter int MAX_OVERS = 20,
  parameter int MAX_WKTS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       evt_valid,
  output logic       evt_ready,
  input  logic [2:0] evt_runs,
  input  logic [1:0] evt_extra,
  input  logic       evt_wicket,
  input  logic       target_en,
  input  logic [9:0] target,
  output logic       inc_s,
  output logic       inc_b,
  output logic       inc_w,
  output logic       over_end,
  output logic       striker,
  output logic       innings_done,
  output logic [9:0] runs_total,
  output logic [3:0] wickets,
  output logic [5:0] overs,
  output logic [2:0] balls,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a delivery event
  // RUNS  | one inc_s pulse per cycle, cnt cycles remaining
  // BALL  | legal-ball accounting and strike rotation
  // WKT   | wicket accounting
  // CHECK | end-of-innings evaluation
  // DONE  | innings over, held until rst
  typedef enum logic [2:0] {IDLE, RUNS, BALL, WKT, CHECK, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic [2:0] runs_l;
  logic [1:0] extra_l;
  logic       wkt_l;
  logic       ten_l;
  logic [9:0] tgt_l;

  logic [2:0] runs_c;
  logic [2:0] n_in;
  logic       accept;
  logic       legal;
  logic       done_cond;

  assign runs_c    = (evt_runs == 3'd7) ? 3'd6 : evt_runs;
  assign n_in      = runs_c + {2'b00, (evt_extra == 2'b01) || (evt_extra == 2'b10)};
  assign accept    = evt_valid && evt_ready;
  assign legal     = (extra_l == 2'b00) || (extra_l == 2'b11);
  assign done_cond = (wickets == 4'(MAX_WKTS)) || (overs == 6'(MAX_OVERS)) ||
                     (ten_l && (runs_total > tgt_l));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    evt_ready = 1'b0;
    inc_s     = 1'b0;
    inc_b     = 1'b0;
    inc_w     = 1'b0;
    over_end  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        evt_ready = 1'b1;
        if (accept) state_nx = (n_in != 3'd0) ? RUNS : BALL;
      end
      RUNS: begin
        busy  = 1'b1;
        inc_s = 1'b1;
        if (cnt == 3'd1) state_nx = BALL;
      end
      BALL: begin
        busy     = 1'b1;
        inc_b    = legal;
        over_end = legal && (balls == 3'd5);
        state_nx = WKT;
      end
      WKT: begin
        busy     = 1'b1;
        inc_w    = wkt_l;
        state_nx = CHECK;
      end
      CHECK: begin
        busy     = 1'b1;
        state_nx = done_cond ? DONE : IDLE;
      end
      DONE: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    // Reset wins immediately so a pulse train cannot leak into the reset cycle.
    if (rst) begin
      evt_ready = 1'b0;
      inc_s     = 1'b0;
      inc_b     = 1'b0;
      inc_w     = 1'b0;
      over_end  = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 3'd0;
      runs_l       <= 3'd0;
      extra_l      <= 2'b00;
      wkt_l        <= 1'b0;
      ten_l        <= 1'b0;
      tgt_l        <= 10'd0;
      striker      <= 1'b0;
      innings_done <= 1'b0;
      runs_total   <= 10'd0;
      wickets      <= 4'd0;
      overs        <= 6'd0;
      balls        <= 3'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt     <= n_in;
          runs_l  <= runs_c;
          extra_l <= evt_extra;
          wkt_l   <= evt_wicket;
          ten_l   <= target_en;
          tgt_l   <= target;
        end
        RUNS: begin
          cnt <= cnt - 3'd1;
          if (runs_total != 10'd999) runs_total <= runs_total + 10'd1;
        end
        BALL: begin
          if (legal) begin
            if (balls == 3'd5) begin
              balls <= 3'd0;
              overs <= overs + 6'd1;
            end else begin
              balls <= balls + 3'd1;
            end
          end
          // Odd runs swap ends; the end of an over swaps them back.
          striker <= striker ^ (runs_l[0] ^ over_end);
        end
        WKT:   if (wkt_l) wickets <= wickets + 4'd1;
        CHECK: if (done_cond) innings_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_innings_ctrl.sv
// Bench for innings_ctrl: directed scenarios plus random innings checked
// against an arithmetic scorecard model.
module tb_innings_ctrl;
  localparam int MAX_OVERS = 20;
  localparam int MAX_WKTS  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       evt_valid, evt_ready;
  logic [2:0] evt_runs;
  logic [1:0] evt_extra;
  logic       evt_wicket, target_en;
  logic [9:0] target;
  logic       inc_s, inc_b, inc_w, over_end, striker, innings_done, busy;
  logic [9:0] runs_total;
  logic [3:0] wickets;
  logic [5:0] overs;
  logic [2:0] balls;

  innings_ctrl #(.MAX_OVERS(MAX_OVERS), .MAX_WKTS(MAX_WKTS)) dut (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_runs(evt_runs), .evt_extra(evt_extra), .evt_wicket(evt_wicket),
    .target_en(target_en), .target(target), .inc_s(inc_s), .inc_b(inc_b),
    .inc_w(inc_w), .over_end(over_end), .striker(striker),
    .innings_done(innings_done), .runs_total(runs_total), .wickets(wickets),
    .overs(overs), .balls(balls), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_runs, m_legal, m_wkts;
  bit m_str, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_runs = 0; m_legal = 0; m_wkts = 0; m_str = 0; m_done = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    evt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_runs"},  runs_total, m_runs);
    check({tag, "_wkts"},  wickets, m_wkts);
    check({tag, "_overs"}, overs, m_legal / 6);
    check({tag, "_balls"}, balls, m_legal % 6);
    check({tag, "_str"},   striker, m_str);
    check({tag, "_done"},  innings_done, m_done);
  endtask

  // Called at a sample point where the controller should be ready.
  task automatic do_event(input int r, input int ex, input bit w, input bit te, input int tg);
    int rc, n, cs, cb, cw, co, k, dbl, nbusy;
    bit legal, oe;
    rc    = (r == 7) ? 6 : r;
    n     = rc + ((ex == 1 || ex == 2) ? 1 : 0);
    legal = (ex == 0 || ex == 3);
    check("ready_pre", evt_ready, 1);
    evt_runs = 3'(r); evt_extra = 2'(ex); evt_wicket = w;
    target_en = te; target = 10'(tg);
    evt_valid = 1'b1;
    @(posedge clk);
    #1 evt_valid = 1'b0;
    cs = 0; cb = 0; cw = 0; co = 0; k = 0; dbl = 0; nbusy = 0;
    while (!evt_ready && !innings_done && k < 20) begin
      cs += int'(inc_s); cb += int'(inc_b); cw += int'(inc_w); co += int'(over_end);
      if (int'(inc_s) + int'(inc_b) + int'(inc_w) > 1) dbl++;
      if (!busy) nbusy++;
      k++;
      @(posedge clk);
      #1;
    end
    m_runs = (m_runs + n > 999) ? 999 : m_runs + n;
    oe = 1'b0;
    if (legal) begin
      m_legal++;
      oe = (m_legal % 6 == 0);
    end
    if (w) m_wkts++;
    m_str = m_str ^ ((rc % 2 == 1) ^ oe);
    m_done = (m_wkts == MAX_WKTS) || (m_legal / 6 == MAX_OVERS) || (te && m_runs > tg);
    check("latency",  k, n + 3);
    check("n_inc_s",  cs, n);
    check("n_inc_b",  cb, legal);
    check("n_inc_w",  cw, w);
    check("over_end", co, oe);
    check("overlap",  dbl, 0);
    check("busy_low", nbusy, 0);
    check_totals("evt");
    check("ready_post", evt_ready, !m_done);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs;
    rst = 1'b1; evt_valid = 1'b0; evt_runs = 3'd0; evt_extra = 2'd0;
    evt_wicket = 1'b0; target_en = 1'b0; target = 10'd0;
    do_reset();
    check("rst_ready", evt_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", {inc_s, inc_b, inc_w, over_end}, 0);
    check_totals("rst");

    // Boundary from the first-event and wide scenarios
    do_event(4, 0, 0, 0, 0);
    check("first_runs", runs_total, 4);
    check("first_balls", balls, 1);
    do_event(1, 1, 0, 0, 0);
    check("wide_runs", runs_total, 6);
    check("wide_balls", balls, 1);
    check("wide_str", striker, 1);

    // Over completes on a single: striker stays
    do_reset();
    repeat (5) do_event(0, 0, 0, 0, 0);
    do_event(1, 0, 0, 0, 0);
    check("over_overs", overs, 1);
    check("over_balls", balls, 0);
    check("over_str", striker, 0);

    // All out, then a further event is ignored
    do_reset();
    repeat (MAX_WKTS) do_event(0, 0, 1, 0, 0);
    check("allout_done", innings_done, 1);
    check("allout_ready", evt_ready, 0);
    evt_valid = 1'b1;
    cs = 0;
    repeat (6) begin
      @(posedge clk);
      #1 cs += int'(inc_s) + int'(inc_b) + int'(inc_w) + int'(busy);
    end
    evt_valid = 1'b0;
    check("done_ignore", cs, 0);
    check("done_wkts", wickets, MAX_WKTS);

    // Chase: target passed vs equalled
    do_reset();
    do_event(3, 0, 0, 0, 0);
    do_event(3, 0, 0, 1, 5);
    check("chase_done", innings_done, 1);
    do_reset();
    do_event(3, 0, 0, 0, 0);
    do_event(3, 0, 0, 1, 6);
    check("chase_open", innings_done, 0);

    // Reset in the middle of a six-run train
    do_reset();
    evt_runs = 3'd6; evt_extra = 2'd0; evt_wicket = 1'b0; target_en = 1'b0;
    evt_valid = 1'b1;
    @(posedge clk);
    #1 evt_valid = 1'b0;
    check("train_s1", inc_s, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("mid_rst_s", inc_s, 0);
    @(posedge clk);
    #1;
    check("post_rst_s", inc_s, 0);
    check("post_rst_runs", runs_total, 0);
    check("post_rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", evt_ready, 1);
    model_reset();

    // Saturation at 999
    repeat (143) do_event(6, 1, 0, 0, 0);
    check("sat_runs", runs_total, 999);
    do_event(6, 0, 0, 0, 0);
    check("sat_hold", runs_total, 999);

    // Random innings
    for (int inn = 0; inn < 4; inn++) begin
      bit te;
      int tg;
      do_reset();
      te = 1'($urandom % 2);
      tg = $urandom_range(60, 250);
      for (int i = 0; i < 300 && !m_done; i++)
        do_event($urandom % 8, $urandom % 4, ($urandom % 8) == 0, te, tg);
      check("rand_done", innings_done, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/innings_ctrl.md
Name: innings_ctrl

Overview:
- Clocked sequencer for the scorecard counters (runs BCD, overs/ball, wickets) and the seven-segment digits they drive.
- Accepts one delivery event per handshake: runs, extra type and wicket flag.
- Serialises each event into single-cycle increment pulses (inc_s, inc_b, inc_w) for the counters.
- Keeps binary shadow totals, tracks the striker, and detects end of innings (all out, overs exhausted, target passed).

Parameters:
- MAX_OVERS, 20, overs per innings (1..63).
- MAX_WKTS, 10, wickets that end the innings (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- evt_valid  in  1  delivery event present.
- evt_ready  out  1  controller can accept an event.
- evt_runs  in  3  runs off the bat/run; 0..6, value 7 is clamped to 6.
- evt_extra  in  2  00 none, 01 wide, 10 no-ball, 11 bye/leg-bye.
- evt_wicket  in  1  wicket fell on this delivery.
- target_en  in  1  chase mode enable; sampled at acceptance.
- target  in  10  runs to beat; sampled at acceptance.
- inc_s  out  1  one-cycle pulse: +1 run to the score counter.
- inc_b  out  1  one-cycle pulse: +1 legal ball to the ball/over counter.
- inc_w  out  1  one-cycle pulse: +1 wicket.
- over_end  out  1  one-cycle pulse when the 6th legal ball completes an over.
- striker  out  1  0 = batter A on strike, 1 = batter B on strike.
- innings_done  out  1  sticky end-of-innings flag.
- runs_total  out  10  binary run total, saturates at 999.
- wickets  out  4  binary wicket count.
- overs  out  6  completed overs.
- balls  out  3  legal balls in the current over, 0..5.
- busy  out  1  high in any state other than IDLE and DONE.

Behaviour:
- Reset: rst is sampled on clk and overrides everything, including an in-flight pulse train. All outputs go to 0 and state goes to IDLE. evt_ready is 1 in the cycle after rst deasserts.
- FSM states: IDLE, RUNS, BALL, WKT, CHECK, DONE.
- IDLE:
  - evt_ready=1.
  - On evt_valid&&evt_ready in cycle T, latch the event, target_en and target.
  - Compute N = clamp(evt_runs) + (evt_extra is 01 or 10 ? 1 : 0), so N is 0..7.
  - Next state is RUNS if N>0, else BALL.
- RUNS:
  - inc_s=1 for exactly N consecutive cycles, T+1..T+N.
  - runs_total increments by 1 per cycle, holding at 999 once reached. inc_s still pulses at 999 (the counter wraps on its own).
- BALL (1 cycle):
  - legal = (evt_extra is 00 or 11). If legal: inc_b=1; balls increments, or if balls was 5, balls←0, overs+1 and over_end=1.
  - Striker toggle conditions:
    - clamp(evt_runs) is odd.
    - over_end fires this cycle.
  - striker ^= (odd runs) XOR (over_end). If both hold, striker is unchanged.
- WKT (1 cycle): if evt_wicket, inc_w=1 and wickets+1. A wicket on a wide or no-ball is still counted.
- CHECK (1 cycle), done if any of:
  - wickets==MAX_WKTS.
  - overs==MAX_OVERS.
  - target_en && runs_total > target.
  - If done: innings_done←1 and go to DONE; else go to IDLE.
- Latency: the event accepted at T gives evt_ready=1 again at T+N+4. The controller issues at most one of inc_s/inc_b/inc_w per cycle, never two.
- DONE: evt_ready=0, busy=0, no pulses. Held until rst. evt_valid is ignored.
- evt_valid while busy: no effect; the source must hold it until evt_ready.
- Totals update in the same cycle as their pulse. Downstream counters and this block share rst, so they stay aligned.

Test Plan:
- rst for 2 cycles, then event runs=4/extra=00/wkt=0 → inc_s high cycles T+1..T+4, inc_b at T+5, no inc_w. runs_total=4, balls=1, striker=0, evt_ready back at T+8.
- Wide with runs=1 → 2 inc_s pulses, no inc_b. balls unchanged. striker toggles (1 is odd). runs_total +2.
- Six legal dot balls, the 6th with runs=1:
  - 6th ball: over_end pulse, balls=0, overs=1.
  - striker unchanged on that ball (odd XOR over_end).
- MAX_WKTS=10: ten wicket events (runs=0, extra=00) → inc_w ×10; after 10th CHECK, innings_done=1 and evt_ready=0. An 11th evt_valid produces no pulses.
- target_en=1, target=5, runs_total=3, event runs=3 → runs_total=6, innings_done=1 after CHECK. Repeat with target=6 → not done.
- Assert rst during the 3rd cycle of a 6-run RUNS train → the next cycle has no inc_s, all totals=0, state IDLE. Runs_total=999 plus 6 runs → stays 999.
